// File: rtl/run_sequencer.sv
// run_sequencer: issues NUM_RUNS go pulses, awaiting each done_sig rise, with gap and timeout supervision
//   clk        12 MHz system clock, posedge
//   rst        asynchronous active-high reset
//   start      one-cycle sequence request (debounced, edge-detected)
//   done_sig   run-finished level from the counting FSM, rising edge counts
//   go         one-cycle run request, decoded from state
//   busy       sequence in progress, decoded from state
//   complete   registered one-cycle pulse when the last run finishes
//   error      registered, high while in FAULT
//   run_count  registered count of finished runs
//   led        registered status: run_count, or 4'hF in FAULT
module run_sequencer #(
    parameter int          NUM_RUNS       = 4,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd12_000_000,
    parameter logic [15:0] GAP_CYCLES     = 16'd1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       done_sig,
    output logic       go,
    output logic       busy,
    output logic       complete,
    output logic       error,
    output logic [3:0] run_count,
    output logic [3:0] led
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] ISSUE     = 3'd1;
    localparam logic [2:0] WAIT_DONE = 3'd2;
    localparam logic [2:0] GAP       = 3'd3;
    localparam logic [2:0] FAULT     = 3'd4;
    localparam logic [3:0] LAST      = 4'(NUM_RUNS);

    logic [2:0]  state, state_n;
    logic [23:0] timer, timer_n;
    logic [3:0]  run_count_n;
    logic        done_prev, done_edge, last_run;

    assign done_edge = done_sig & ~done_prev;
    assign last_run  = (run_count + 4'd1) == LAST;

    // led/error follow the next state so they change on the same edge as the state
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state     <= IDLE;
            timer     <= '0;
            run_count <= '0;
            done_prev <= 1'b0;
            complete  <= 1'b0;
            error     <= 1'b0;
            led       <= '0;
        end else begin
            state     <= state_n;
            timer     <= timer_n;
            run_count <= run_count_n;
            done_prev <= done_sig;
            complete  <= state == WAIT_DONE && done_edge && last_run;
            error     <= state_n == FAULT;
            led       <= state_n == FAULT ? 4'hF : run_count_n;
        end

    always_comb begin
        state_n     = IDLE;
        timer_n     = timer;
        run_count_n = run_count;
        case (state)
            IDLE: begin
                state_n     = start ? ISSUE : IDLE;
                run_count_n = start ? 4'd0 : run_count;
            end
            ISSUE: begin
                state_n = WAIT_DONE;
                timer_n = '0;
            end
            WAIT_DONE: begin
                // a done edge on the timeout cycle still counts the run
                timer_n     = done_edge ? 24'd0 : timer + 24'd1;
                run_count_n = done_edge ? run_count + 4'd1 : run_count;
                state_n     = done_edge ? (last_run ? IDLE : GAP) :
                              timer == TIMEOUT_CYCLES - 24'd1 ? FAULT : WAIT_DONE;
            end
            GAP: begin
                timer_n = timer + 24'd1;
                state_n = timer == {8'd0, GAP_CYCLES} - 24'd1 ? ISSUE : GAP;
            end
            FAULT:   state_n = start ? IDLE : FAULT;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        go   = state == ISSUE;
        busy = state == ISSUE || state == WAIT_DONE || state == GAP;
    end
endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer: directed checks of run_sequencer with NUM_RUNS=3, TIMEOUT_CYCLES=100, GAP_CYCLES=5
module tb_run_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       done_sig = 1'b0;
    logic       go, busy, complete, error;
    logic [3:0] run_count, led;
    int         nchecks = 0;
    int         nerr = 0;

    run_sequencer #(.NUM_RUNS(3), .TIMEOUT_CYCLES(24'd100), .GAP_CYCLES(16'd5)) dut (
        .clk(clk), .rst(rst), .start(start), .done_sig(done_sig), .go(go), .busy(busy),
        .complete(complete), .error(error), .run_count(run_count), .led(led)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        start = 1'b0;
        done_sig = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        tick();
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // entered in the ISSUE cycle; responder answers 10 cycles after go
    task automatic do_run(input string name, input logic [3:0] rc, input logic last);
        done_sig = 1'b0;
        repeat (9) tick();
        done_sig = 1'b1;
        tick();
        nchecks++; if (run_count !== rc) begin nerr++; $display("FAIL %s rc: got %0d want %0d", name, run_count, rc); end
        nchecks++; if (led !== rc) begin nerr++; $display("FAIL %s led: got %0d want %0d", name, led, rc); end
        nchecks++; if (complete !== last) begin nerr++; $display("FAIL %s complete: got %0b want %0b", name, complete, last); end
        nchecks++; if (busy !== !last) begin nerr++; $display("FAIL %s busy: got %0b want %0b", name, busy, !last); end
        nchecks++; if (error !== 1'b0) begin nerr++; $display("FAIL %s error: got %0b want 0", name, error); end
        if (last) begin
            tick();
            nchecks++; if (complete !== 1'b0) begin nerr++; $display("FAIL %s complete_width: got %0b want 0", name, complete); end
            nchecks++; if (busy !== 1'b0) begin nerr++; $display("FAIL %s busy_after: got %0b want 0", name, busy); end
        end else begin
            repeat (4) begin
                tick();
                nchecks++; if (go !== 1'b0) begin nerr++; $display("FAIL %s gap_go: got %0b want 0", name, go); end
            end
            tick();
            nchecks++; if (go !== 1'b1) begin nerr++; $display("FAIL %s next_go: got %0b want 1", name, go); end
        end
    endtask

    task automatic test_reset;
        repeat (2) tick();
        nchecks++; if ({go, busy, complete, error, run_count, led} !== 12'd0) begin nerr++; $display("FAIL reset_outputs: got %h want 000", {go, busy, complete, error, run_count, led}); end
        rst = 1'b0;
        tick();
        nchecks++; if ({go, busy, error} !== 3'd0) begin nerr++; $display("FAIL reset_idle: got %b want 000", {go, busy, error}); end
    endtask

    task automatic test_nominal;
        pulse_start();
        nchecks++; if (go !== 1'b1) begin nerr++; $display("FAIL nom_go1: got %0b want 1", go); end
        nchecks++; if (busy !== 1'b1) begin nerr++; $display("FAIL nom_busy: got %0b want 1", busy); end
        tick();
        nchecks++; if (go !== 1'b0) begin nerr++; $display("FAIL nom_go_width: got %0b want 0", go); end
        done_sig = 1'b0;
        repeat (8) tick();
        done_sig = 1'b1;
        tick();
        nchecks++; if (run_count !== 4'd1) begin nerr++; $display("FAIL nom_rc1: got %0d want 1", run_count); end
        repeat (4) tick();
        tick();
        nchecks++; if (go !== 1'b1) begin nerr++; $display("FAIL nom_go2: got %0b want 1", go); end
        do_run("nom_run2", 4'd2, 1'b0);
        do_run("nom_run3", 4'd3, 1'b1);
        done_sig = 1'b0;
        tick();
    endtask

    task automatic test_timeout;
        pulse_start();
        do_run("to_run1", 4'd1, 1'b0);
        done_sig = 1'b0;
        repeat (100) tick();
        nchecks++; if (error !== 1'b0) begin nerr++; $display("FAIL to_early: got %0b want 0", error); end
        tick();
        nchecks++; if (error !== 1'b1) begin nerr++; $display("FAIL to_error: got %0b want 1", error); end
        nchecks++; if (led !== 4'hF) begin nerr++; $display("FAIL to_led: got %h want f", led); end
        nchecks++; if (run_count !== 4'd1) begin nerr++; $display("FAIL to_rc: got %0d want 1", run_count); end
        nchecks++; if (busy !== 1'b0) begin nerr++; $display("FAIL to_busy: got %0b want 0", busy); end
        pulse_start();
        nchecks++; if (error !== 1'b0) begin nerr++; $display("FAIL to_clear: got %0b want 0", error); end
        nchecks++; if (go !== 1'b0) begin nerr++; $display("FAIL to_no_go: got %0b want 0", go); end
        nchecks++; if (led !== 4'd1) begin nerr++; $display("FAIL to_led_idle: got %h want 1", led); end
        tick();
        nchecks++; if (go !== 1'b0) begin nerr++; $display("FAIL to_idle_go: got %0b want 0", go); end
        pulse_start();
        nchecks++; if (go !== 1'b1) begin nerr++; $display("FAIL to_restart_go: got %0b want 1", go); end
        nchecks++; if (run_count !== 4'd0) begin nerr++; $display("FAIL to_restart_rc: got %0d want 0", run_count); end
        do_reset();
    endtask

    task automatic test_stale;
        done_sig = 1'b1;
        repeat (3) tick();
        pulse_start();
        repeat (15) tick();
        nchecks++; if (run_count !== 4'd0) begin nerr++; $display("FAIL stale_rc: got %0d want 0", run_count); end
        nchecks++; if (busy !== 1'b1) begin nerr++; $display("FAIL stale_busy: got %0b want 1", busy); end
        done_sig = 1'b0;
        tick();
        done_sig = 1'b1;
        tick();
        nchecks++; if (run_count !== 4'd1) begin nerr++; $display("FAIL stale_rc_after: got %0d want 1", run_count); end
        do_reset();
    endtask

    task automatic test_race;
        pulse_start();
        done_sig = 1'b0;
        repeat (100) tick();
        done_sig = 1'b1;
        tick();
        nchecks++; if (run_count !== 4'd1) begin nerr++; $display("FAIL race_rc: got %0d want 1", run_count); end
        nchecks++; if (error !== 1'b0) begin nerr++; $display("FAIL race_error: got %0b want 0", error); end
        nchecks++; if (busy !== 1'b1) begin nerr++; $display("FAIL race_busy: got %0b want 1", busy); end
        repeat (5) tick();
        nchecks++; if (go !== 1'b1) begin nerr++; $display("FAIL race_gap_go: got %0b want 1", go); end
        do_reset();
    endtask

    task automatic test_ignored;
        pulse_start();
        done_sig = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        nchecks++; if (go !== 1'b0 || run_count !== 4'd0) begin nerr++; $display("FAIL ign_wait: got go=%0b rc=%0d want go=0 rc=0", go, run_count); end
        repeat (6) tick();
        done_sig = 1'b1;
        tick();
        nchecks++; if (run_count !== 4'd1) begin nerr++; $display("FAIL ign_rc1: got %0d want 1", run_count); end
        done_sig = 1'b0;
        tick();
        done_sig = 1'b1;
        tick();
        nchecks++; if (run_count !== 4'd1 || go !== 1'b0) begin nerr++; $display("FAIL ign_gap_done: got rc=%0d go=%0b want rc=1 go=0", run_count, go); end
        pulse_start();
        nchecks++; if (go !== 1'b0 || run_count !== 4'd1) begin nerr++; $display("FAIL ign_gap_start: got go=%0b rc=%0d want go=0 rc=1", go, run_count); end
        tick();
        tick();
        nchecks++; if (go !== 1'b1) begin nerr++; $display("FAIL ign_go2: got %0b want 1", go); end
        do_run("ign_run2", 4'd2, 1'b0);
        do_run("ign_run3", 4'd3, 1'b1);
        done_sig = 1'b0;
        tick();
        done_sig = 1'b1;
        tick();
        nchecks++; if (run_count !== 4'd3 || busy !== 1'b0) begin nerr++; $display("FAIL ign_idle_done: got rc=%0d busy=%0b want rc=3 busy=0", run_count, busy); end
        do_reset();
    endtask

    task automatic test_async_reset;
        logic bad_go, bad_complete;
        pulse_start();
        do_run("ar_run1", 4'd1, 1'b0);
        done_sig = 1'b0;
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        nchecks++; if ({go, busy, complete, error, run_count, led} !== 12'd0) begin nerr++; $display("FAIL ar_async: got %h want 000", {go, busy, complete, error, run_count, led}); end
        #1 rst = 1'b0;
        bad_go = 1'b0;
        bad_complete = 1'b0;
        for (int i = 0; i < 30; i++) begin
            done_sig = (i >= 5 && i < 12) || i >= 20;
            tick();
            bad_go |= go;
            bad_complete |= complete;
        end
        nchecks++; if (bad_go !== 1'b0) begin nerr++; $display("FAIL ar_no_go: got %0b want 0", bad_go); end
        nchecks++; if (bad_complete !== 1'b0) begin nerr++; $display("FAIL ar_no_complete: got %0b want 0", bad_complete); end
        done_sig = 1'b0;
        pulse_start();
        nchecks++; if (go !== 1'b1 || run_count !== 4'd0) begin nerr++; $display("FAIL ar_restart: got go=%0b rc=%0d want go=1 rc=0", go, run_count); end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_timeout();
        test_stale();
        test_race();
        test_ignored();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end
endmodule
